sha256_stream_padder: RTL and testbench

- Initiator side of the sha256_core init/next/block/ready interface.
- Accepts a message as a byte stream, applies FIPS 180-4 padding (0x80, zero fill, 64-bit big-endian bit length), and assembles 512-bit blocks.
- Issues each block to sha256_core with init for the first block and next for later blocks.
- Latches the final digest and presents it to the system. Sits between a byte-stream source (e.g. bus/DMA) and sha256_core.

---
 rtl/sha256_pkg.sv | 27 ++
 rtl/sha256_block_buf.sv | 60 ++++++
 rtl/sha256_stream_padder.sv | 213 +++++++++++++++++++++
 tb/tb_sha256_stream_padder.sv | 487 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// Shared constants, FSM state type and length-field helper for the SHA-256 stream padder.
package sha256_pkg;

  localparam int BLOCK_BITS  = 512;
  localparam int DIGEST_BITS = 256;
  localparam int BLOCK_BYTES = 64;

  localparam logic [7:0] PAD_BYTE = 8'h80;
  localparam logic [5:0] LEN_POS  = 6'd56;
  localparam logic [5:0] LAST_IDX = 6'd63;

  typedef enum logic [2:0] {
    FILL  = 3'd0,
    PAD   = 3'd1,
    LEN   = 3'd2,
    ISSUE = 3'd3,
    WAIT  = 3'd4
  } state_e;

  // Byte of the big-endian 64-bit length that lands at block position idx (56..63).
  function automatic logic [7:0] len_byte(input logic [63:0] len, input logic [5:0] idx);
    logic [5:0] sh;
    sh = {3'd7 - idx[2:0], 3'b000};
    len_byte = 8'(len >> sh);
  endfunction

endpackage

// File: rtl/sha256_block_buf.sv
// 64-byte block assembly register: indexed byte writes, auto-incrementing index,
// and a flag that marks the block complete once byte 63 has been written.
module sha256_block_buf
  import sha256_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clr_i,
  input  logic                  wr_i,
  input  logic [7:0]            wr_data_i,
  output logic [BLOCK_BITS-1:0] block_o,
  output logic [5:0]            idx_o,
  output logic                  full_o
);

  logic [7:0] mem_q [BLOCK_BYTES];
  logic [5:0] idx_q, idx_d;
  logic       full_q, full_d;

  always_comb begin
    idx_d  = idx_q;
    full_d = full_q;
    if (clr_i) begin
      idx_d  = 6'd0;
      full_d = 1'b0;
    end else if (wr_i) begin
      idx_d  = idx_q + 6'd1;
      full_d = (idx_q == LAST_IDX);
    end else begin
      idx_d  = idx_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q  <= 6'd0;
      full_q <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      full_q <= full_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < BLOCK_BYTES; i++) mem_q[i] <= 8'h00;
    end else if (wr_i && !clr_i) begin
      mem_q[idx_q] <= wr_data_i;
    end
  end

  // Byte 0 occupies the most significant byte of the block.
  for (genvar g = 0; g < BLOCK_BYTES; g++) begin : g_pack
    assign block_o[BLOCK_BITS-1-8*g -: 8] = mem_q[g];
  end

  assign idx_o  = idx_q;
  assign full_o = full_q;

endmodule

// File: rtl/sha256_stream_padder.sv
// Byte-stream front end for sha256_core: pads each message, issues 512-bit blocks
// with init/next, and latches the final digest.
module sha256_stream_padder
  import sha256_pkg::*;
#(
  parameter int LEN_WIDTH = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [7:0]             in_data,
  input  logic                   in_last,
  output logic                   core_init,
  output logic                   core_next,
  output logic [BLOCK_BITS-1:0]  core_block,
  input  logic                   core_ready,
  input  logic [DIGEST_BITS-1:0] core_digest,
  output logic [DIGEST_BITS-1:0] digest,
  output logic                   digest_valid,
  output logic                   busy
);

  state_e                 state_q, state_d;
  logic                   ret_pad_q, ret_pad_d;
  logic                   final_q, final_d;
  logic                   first_blk_q, first_blk_d;
  logic                   marker_q, marker_d;
  logic                   wait_first_q, wait_first_d;
  logic [LEN_WIDTH-1:0]   len_q, len_d;
  logic                   busy_q, busy_d;
  logic                   dv_q, dv_d;
  logic [DIGEST_BITS-1:0] digest_q, digest_d;
  logic                   init_q, init_d;
  logic                   next_q, next_d;
  logic                   in_ready_q, in_ready_d;

  logic                   wr_s;
  logic [7:0]             wr_data_s;
  logic                   clr_s;
  logic [5:0]             idx_s;
  logic                   full_s;
  logic [63:0]            len64_s;

  assign len64_s = 64'(len_q);

  sha256_block_buf u_buf (
    .clk       (clk),
    .reset     (reset),
    .clr_i     (clr_s),
    .wr_i      (wr_s),
    .wr_data_i (wr_data_s),
    .block_o   (core_block),
    .idx_o     (idx_s),
    .full_o    (full_s)
  );

  always_comb begin
    state_d      = state_q;
    ret_pad_d    = ret_pad_q;
    final_d      = final_q;
    first_blk_d  = first_blk_q;
    marker_d     = marker_q;
    wait_first_d = 1'b0;
    len_d        = len_q;
    busy_d       = busy_q;
    dv_d         = dv_q;
    digest_d     = digest_q;
    init_d       = 1'b0;
    next_d       = 1'b0;
    wr_s         = 1'b0;
    wr_data_s    = 8'h00;
    clr_s        = 1'b0;

    case (state_q)
      FILL: begin
        if (in_valid && in_ready_q) begin
          wr_s      = 1'b1;
          wr_data_s = in_data;
          if (!busy_q) begin
            // First byte of a new message: restart length and drop the old digest.
            len_d       = LEN_WIDTH'(4'd8);
            busy_d      = 1'b1;
            dv_d        = 1'b0;
            first_blk_d = 1'b1;
          end else begin
            len_d = len_q + LEN_WIDTH'(4'd8);
          end
          if (in_last) begin
            marker_d = 1'b0;
            if (idx_s == LAST_IDX) begin
              ret_pad_d = 1'b1;
              state_d   = ISSUE;
            end else begin
              state_d   = PAD;
            end
          end else if (idx_s == LAST_IDX) begin
            ret_pad_d = 1'b0;
            state_d   = ISSUE;
          end else begin
            state_d   = FILL;
          end
        end else begin
          state_d = FILL;
        end
      end

      PAD: begin
        wr_s      = 1'b1;
        wr_data_s = marker_q ? 8'h00 : PAD_BYTE;
        marker_d  = 1'b1;
        if (idx_s == LAST_IDX) begin
          ret_pad_d = 1'b1;
          state_d   = ISSUE;
        end else if (idx_s == LEN_POS - 6'd1) begin
          state_d   = LEN;
        end else begin
          state_d   = PAD;
        end
      end

      LEN: begin
        wr_s      = 1'b1;
        wr_data_s = len_byte(len64_s, idx_s);
        if (idx_s == LAST_IDX) begin
          final_d = 1'b1;
          state_d = ISSUE;
        end else begin
          state_d = LEN;
        end
      end

      ISSUE: begin
        if (core_ready && full_s) begin
          if (first_blk_q) begin
            init_d = 1'b1;
          end else begin
            next_d = 1'b1;
          end
          first_blk_d  = 1'b0;
          clr_s        = 1'b1;
          wait_first_d = 1'b1;
          state_d      = WAIT;
        end else begin
          state_d = ISSUE;
        end
      end

      WAIT: begin
        // core_ready during the pulse cycle still reflects the previous operation.
        if (!wait_first_q && core_ready) begin
          if (final_q) begin
            digest_d = core_digest;
            dv_d     = 1'b1;
            busy_d   = 1'b0;
            final_d  = 1'b0;
            state_d  = FILL;
          end else begin
            state_d  = ret_pad_q ? PAD : FILL;
          end
        end else begin
          state_d = WAIT;
        end
      end

      default: begin
        state_d = FILL;
      end
    endcase

    in_ready_d = (state_d == FILL);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= FILL;
      ret_pad_q    <= 1'b0;
      final_q      <= 1'b0;
      first_blk_q  <= 1'b1;
      marker_q     <= 1'b0;
      wait_first_q <= 1'b0;
      len_q        <= '0;
      busy_q       <= 1'b0;
      dv_q         <= 1'b0;
      digest_q     <= '0;
      init_q       <= 1'b0;
      next_q       <= 1'b0;
      in_ready_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      ret_pad_q    <= ret_pad_d;
      final_q      <= final_d;
      first_blk_q  <= first_blk_d;
      marker_q     <= marker_d;
      wait_first_q <= wait_first_d;
      len_q        <= len_d;
      busy_q       <= busy_d;
      dv_q         <= dv_d;
      digest_q     <= digest_d;
      init_q       <= init_d;
      next_q       <= next_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign core_init    = init_q;
  assign core_next    = next_q;
  assign digest       = digest_q;
  assign digest_valid = dv_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_sha256_stream_padder.sv
// Self-checking bench: behavioural SHA-256 core model plus a queue-based padding
// and hashing reference for the stream padder.
module tb_sha256_stream_padder;

  logic         clk;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [7:0]   in_data;
  logic         in_last;
  logic         core_init;
  logic         core_next;
  logic [511:0] core_block;
  logic         core_ready;
  logic [255:0] core_digest;
  logic [255:0] digest;
  logic         digest_valid;
  logic         busy;

  logic model_ready;
  logic hold_busy;
  assign core_ready = model_ready & ~hold_busy;

  int errors = 0;
  int checks = 0;

  logic [511:0] obs_blk[$];
  bit           obs_init[$];
  int           pulse_total = 0;
  int           bad_pulse = 0;

  localparam logic [255:0] H_IV =
    256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [255:0] ABC_DIG =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] TWO_DIG =
    256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  sha256_stream_padder #(.LEN_WIDTH(64)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_last      (in_last),
    .core_init    (core_init),
    .core_next    (core_next),
    .core_block   (core_block),
    .core_ready   (core_ready),
    .core_digest  (core_digest),
    .digest       (digest),
    .digest_valid (digest_valid),
    .busy         (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: got simulation still running want finished");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] sha_compress(input logic [255:0] hin, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2, s0, s1;
    for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      s0 = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
      s1 = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = s1 + w[i-7] + s0 + w[i-16];
    end
    {a, b, c, d, e, f, g, h} = hin;
    for (int i = 0; i < 64; i++) begin
      t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + K[i] + w[i];
      t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    return {hin[255:224] + a, hin[223:192] + b, hin[191:160] + c, hin[159:128] + d,
            hin[127:96] + e, hin[95:64] + f, hin[63:32] + g, hin[31:0] + h};
  endfunction

  // Reference: padded byte stream cut into blocks, then hashed from the IV.
  task automatic ref_pad(input logic [7:0] m[$], output logic [511:0] blks[$], output logic [255:0] dig);
    logic [7:0]   p[$];
    logic [63:0]  bitlen;
    logic [511:0] blk;
    p = m;
    p.push_back(8'h80);
    while ((p.size() % 64) != 56) p.push_back(8'h00);
    bitlen = 64'(m.size()) * 64'd8;
    for (int i = 7; i >= 0; i--) p.push_back(bitlen[8*i +: 8]);
    blks.delete();
    dig = H_IV;
    for (int bi = 0; bi < p.size() / 64; bi++) begin
      for (int j = 0; j < 64; j++) blk[511-8*j -: 8] = p[64*bi + j];
      blks.push_back(blk);
      dig = sha_compress(dig, blk);
    end
  endtask

  // Behavioural sha256_core: captures each pulse, goes busy, returns the chained hash.
  initial begin : core_model
    logic [255:0] hm;
    int lat;
    model_ready = 1'b1;
    core_digest = '0;
    hm = H_IV;
    forever begin
      @(negedge clk);
      if (core_init || core_next) begin
        obs_blk.push_back(core_block);
        obs_init.push_back(core_init);
        if (core_init) hm = H_IV;
        hm = sha_compress(hm, core_block);
        @(negedge clk);
        model_ready = 1'b0;
        lat = $urandom_range(4, 1);
        repeat (lat) @(negedge clk);
        core_digest = hm;
        model_ready = 1'b1;
      end
    end
  end

  initial begin : pulse_monitor
    bit prev;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (core_init || core_next) pulse_total++;
      if (core_init && core_next) bad_pulse++;
      if ((core_init || core_next) && prev) bad_pulse++;
      prev = core_init || core_next;
    end
  end

  task automatic send_bytes(input logic [7:0] m[$], input int from, input int to,
                            input int gap_pct, output bit ok);
    int t;
    ok = 1'b1;
    for (int i = from; i < to; i++) begin
      if ($urandom_range(99, 0) < gap_pct) begin
        in_valid = 1'b0;
        @(negedge clk);
      end
      in_valid = 1'b1;
      in_data  = m[i];
      in_last  = (i == m.size() - 1);
      t = 0;
      while (!in_ready && t < 2000) begin
        @(negedge clk);
        t++;
      end
      if (t >= 2000) begin
        ok = 1'b0;
        break;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    int t;
    t = 0;
    while (!digest_valid && t < 4000) begin
      @(negedge clk);
      t++;
    end
    ok = digest_valid;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
    checks++;
    if ({core_init, core_next, digest_valid, busy} !== 4'b0000 || digest !== '0 || core_block !== '0) begin
      errors++; $display("FAIL rst_outputs: got init=%b next=%b dv=%b busy=%b want all zero",
                         core_init, core_next, digest_valid, busy);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL rst_release: got in_ready=%b busy=%b want 1 0", in_ready, busy);
    end
  endtask

  task automatic test_abc;
    logic [7:0]   m[$];
    logic [511:0] exp_blk;
    bit ok1, ok2;
    int p0;
    m = {8'h61, 8'h62, 8'h63};
    exp_blk = '0;
    exp_blk[511:480] = 32'h61626380;
    exp_blk[63:0] = 64'h18;
    obs_blk.delete(); obs_init.delete();
    p0 = pulse_total;
    send_bytes(m, 0, 3, 0, ok1);
    wait_done(ok2);
    checks++;
    if (!(ok1 && ok2)) begin errors++; $display("FAIL abc_timeout: got send=%b done=%b want 1 1", ok1, ok2); end
    checks++;
    if (obs_blk.size() != 1 || pulse_total != p0 + 1) begin
      errors++; $display("FAIL abc_pulses: got %0d blocks want 1", obs_blk.size());
    end
    checks++;
    if (obs_init.size() < 1 || obs_init[0] !== 1'b1) begin errors++; $display("FAIL abc_init: got next want init"); end
    checks++;
    if (obs_blk.size() < 1 || obs_blk[0] !== exp_blk) begin
      errors++; $display("FAIL abc_block: got %h want %h", obs_blk.size() > 0 ? obs_blk[0] : '0, exp_blk);
    end
    checks++;
    if (digest !== ABC_DIG) begin errors++; $display("FAIL abc_digest: got %h want %h", digest, ABC_DIG); end
    checks++;
    if (busy !== 1'b0 || digest_valid !== 1'b1) begin
      errors++; $display("FAIL abc_status: got busy=%b dv=%b want 0 1", busy, digest_valid);
    end
  endtask

  task automatic test_two_block;
    string        s;
    logic [7:0]   m[$];
    logic [511:0] rb[$];
    logic [511:0] exp2;
    logic [255:0] rd;
    bit ok1, ok2;
    s = "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq";
    for (int i = 0; i < s.len(); i++) m.push_back(s[i]);
    ref_pad(m, rb, rd);
    exp2 = '0;
    exp2[63:0] = 64'h1C0;
    obs_blk.delete(); obs_init.delete();
    send_bytes(m, 0, m.size(), 20, ok1);
    wait_done(ok2);
    checks++;
    if (!(ok1 && ok2)) begin errors++; $display("FAIL two_timeout: got send=%b done=%b want 1 1", ok1, ok2); end
    checks++;
    if (obs_blk.size() != 2) begin errors++; $display("FAIL two_count: got %0d want 2", obs_blk.size()); end
    checks++;
    if (obs_blk.size() < 2 || obs_init[0] !== 1'b1 || obs_init[1] !== 1'b0) begin
      errors++; $display("FAIL two_kinds: got wrong init/next sequence want init,next");
    end
    checks++;
    if (obs_blk.size() < 2 || obs_blk[0] !== rb[0]) begin errors++; $display("FAIL two_block1: got mismatch want %h", rb[0]); end
    checks++;
    if (obs_blk.size() < 2 || obs_blk[1] !== exp2) begin errors++; $display("FAIL two_block2: got mismatch want %h", exp2); end
    checks++;
    if (digest !== TWO_DIG) begin errors++; $display("FAIL two_digest: got %h want %h", digest, TWO_DIG); end
  endtask

  task automatic test_55;
    logic [7:0]   m[$];
    logic [511:0] rb[$];
    logic [255:0] rd;
    bit ok1, ok2;
    for (int i = 0; i < 55; i++) m.push_back(8'($urandom));
    ref_pad(m, rb, rd);
    obs_blk.delete(); obs_init.delete();
    send_bytes(m, 0, 55, 10, ok1);
    wait_done(ok2);
    checks++;
    if (!(ok1 && ok2)) begin errors++; $display("FAIL m55_timeout: got send=%b done=%b want 1 1", ok1, ok2); end
    checks++;
    if (obs_blk.size() != 1 || obs_init.size() < 1 || obs_init[0] !== 1'b1) begin
      errors++; $display("FAIL m55_count: got %0d blocks want 1 init", obs_blk.size());
    end
    checks++;
    if (obs_blk.size() < 1 || obs_blk[0][63:0] !== 64'h1B8 || obs_blk[0][71:64] !== 8'h80) begin
      errors++; $display("FAIL m55_tail: got bad marker/length want 80 then 1b8");
    end
    checks++;
    if (obs_blk.size() < 1 || obs_blk[0] !== rb[0]) begin errors++; $display("FAIL m55_block: got mismatch want %h", rb[0]); end
    checks++;
    if (digest !== rd) begin errors++; $display("FAIL m55_digest: got %h want %h", digest, rd); end
  endtask

  task automatic test_64;
    logic [7:0]   m[$];
    logic [511:0] rb[$];
    logic [511:0] exp2;
    logic [255:0] rd;
    bit ok1;
    int p0, t, rdy_viol;
    for (int i = 0; i < 64; i++) m.push_back(8'($urandom));
    ref_pad(m, rb, rd);
    exp2 = '0;
    exp2[511:504] = 8'h80;
    exp2[63:0] = 64'h200;
    obs_blk.delete(); obs_init.delete();
    p0 = pulse_total;
    send_bytes(m, 0, 64, 0, ok1);
    t = 0;
    while (pulse_total == p0 && t < 2) begin @(negedge clk); t++; end
    checks++;
    if (!ok1 || pulse_total != p0 + 1) begin
      errors++; $display("FAIL m64_latency: got %0d pulses after 2 cycles want 1", pulse_total - p0);
    end
    rdy_viol = 0;
    t = 0;
    while (!digest_valid && t < 4000) begin
      if (in_ready !== 1'b0) rdy_viol++;
      @(negedge clk);
      t++;
    end
    checks++;
    if (!digest_valid || rdy_viol != 0) begin
      errors++; $display("FAIL m64_in_ready: got %0d ready cycles dv=%b want 0 1", rdy_viol, digest_valid);
    end
    checks++;
    if (obs_blk.size() != 2 || obs_init[0] !== 1'b1 || obs_init[1] !== 1'b0) begin
      errors++; $display("FAIL m64_count: got %0d blocks want 2 (init,next)", obs_blk.size());
    end
    checks++;
    if (obs_blk.size() < 2 || obs_blk[0] !== rb[0] || obs_blk[1] !== exp2) begin
      errors++; $display("FAIL m64_blocks: got mismatch want second %h", exp2);
    end
    checks++;
    if (digest !== rd) begin errors++; $display("FAIL m64_digest: got %h want %h", digest, rd); end
  endtask

  task automatic test_backpressure;
    logic [7:0]   m[$];
    logic [511:0] rb[$];
    logic [255:0] rd;
    bit ok1, ok2, ok3;
    int p0, viol;
    for (int i = 0; i < 100; i++) m.push_back(8'($urandom));
    ref_pad(m, rb, rd);
    obs_blk.delete(); obs_init.delete();
    hold_busy = 1'b1;
    p0 = pulse_total;
    send_bytes(m, 0, 64, 10, ok1);
    viol = 0;
    repeat (100) begin
      @(negedge clk);
      if (in_ready !== 1'b0 || core_block !== rb[0]) viol++;
    end
    checks++;
    if (pulse_total != p0) begin errors++; $display("FAIL bp_no_pulse: got %0d pulses want 0", pulse_total - p0); end
    checks++;
    if (!ok1 || viol != 0) begin errors++; $display("FAIL bp_stable: got %0d bad cycles want 0", viol); end
    hold_busy = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (pulse_total != p0 + 1) begin errors++; $display("FAIL bp_release: got %0d pulses want 1", pulse_total - p0); end
    send_bytes(m, 64, 100, 10, ok2);
    wait_done(ok3);
    checks++;
    if (!(ok2 && ok3) || obs_blk.size() != 2 || obs_blk[0] !== rb[0] || obs_blk[1] !== rb[1]) begin
      errors++; $display("FAIL bp_blocks: got %0d blocks (or mismatch) want 2 matching", obs_blk.size());
    end
    checks++;
    if (digest !== rd) begin errors++; $display("FAIL bp_digest: got %h want %h", digest, rd); end
  endtask

  task automatic test_reset_mid_pad;
    logic [7:0]   a[$];
    logic [7:0]   m[$];
    logic [7:0]   m2[$];
    logic [511:0] rb[$];
    logic [255:0] rd;
    bit ok1, ok2, ok3;
    int p0;
    for (int i = 0; i < 10; i++) a.push_back(8'($urandom));
    p0 = pulse_total;
    send_bytes(a, 0, 10, 0, ok1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || busy !== 1'b0 || digest_valid !== 1'b0 || digest !== '0 || core_block !== '0) begin
      errors++; $display("FAIL midrst_clear: got in_ready=%b busy=%b dv=%b want all zero", in_ready, busy, digest_valid);
    end
    reset = 1'b0;
    repeat (80) @(negedge clk);
    checks++;
    if (pulse_total != p0 || digest_valid !== 1'b0) begin
      errors++; $display("FAIL midrst_no_digest: got pulses=%0d dv=%b want 0 0", pulse_total - p0, digest_valid);
    end
    m = {8'h61, 8'h62, 8'h63};
    obs_blk.delete(); obs_init.delete();
    send_bytes(m, 0, 3, 0, ok2);
    wait_done(ok3);
    checks++;
    if (!(ok1 && ok2 && ok3) || digest !== ABC_DIG || obs_blk.size() != 1 || obs_init[0] !== 1'b1) begin
      errors++; $display("FAIL midrst_abc: got %h want %h", digest, ABC_DIG);
    end
    for (int i = 0; i < 3; i++) m2.push_back(8'($urandom));
    ref_pad(m2, rb, rd);
    in_valid = 1'b1;
    in_data  = m2[0];
    in_last  = 1'b0;
    while (!in_ready) @(negedge clk);
    checks++;
    if (digest_valid !== 1'b1) begin errors++; $display("FAIL dv_hold: got %b want 1", digest_valid); end
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (digest_valid !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL dv_clear: got dv=%b busy=%b want 0 1", digest_valid, busy);
    end
    send_bytes(m2, 1, 3, 0, ok1);
    wait_done(ok2);
    checks++;
    if (!(ok1 && ok2) || digest !== rd) begin errors++; $display("FAIL dv_next_digest: got %h want %h", digest, rd); end
  endtask

  task automatic test_back_to_back;
    int lens [13] = '{1, 2, 54, 55, 56, 57, 62, 63, 64, 65, 119, 120, 128};
    logic [7:0]   m[$];
    logic [511:0] rb[$];
    logic [255:0] rd;
    bit ok1, ok2;
    int n, bad_blk, bad_kind;
    for (int k = 0; k < 22; k++) begin
      n = (k < 13) ? lens[k] : int'($urandom_range(200, 1));
      m.delete();
      for (int i = 0; i < n; i++) m.push_back(8'($urandom));
      ref_pad(m, rb, rd);
      obs_blk.delete(); obs_init.delete();
      send_bytes(m, 0, n, 30, ok1);
      wait_done(ok2);
      checks++;
      if (!(ok1 && ok2)) begin errors++; $display("FAIL rnd_timeout: got len=%0d stalled want completion", n); end
      checks++;
      if (obs_blk.size() != rb.size()) begin
        errors++; $display("FAIL rnd_count: got %0d blocks want %0d (len %0d)", obs_blk.size(), rb.size(), n);
      end
      bad_blk = 0;
      bad_kind = 0;
      for (int b = 0; b < obs_blk.size() && b < rb.size(); b++) begin
        if (obs_blk[b] !== rb[b]) bad_blk++;
        if (obs_init[b] !== (b == 0)) bad_kind++;
      end
      checks++;
      if (bad_blk != 0 || bad_kind != 0) begin
        errors++; $display("FAIL rnd_blocks: got %0d bad blocks %0d bad kinds want 0 0 (len %0d)", bad_blk, bad_kind, n);
      end
      checks++;
      if (digest !== rd) begin errors++; $display("FAIL rnd_digest: got %h want %h (len %0d)", digest, rd, n); end
    end
    checks++;
    if (bad_pulse != 0) begin errors++; $display("FAIL pulse_rules: got %0d violations want 0", bad_pulse); end
  endtask

  initial begin
    in_valid  = 1'b0;
    in_data   = 8'h00;
    in_last   = 1'b0;
    reset     = 1'b1;
    hold_busy = 1'b0;
    test_reset;
    test_abc;
    test_two_block;
    test_55;
    test_64;
    test_backpressure;
    test_reset_mid_pad;
    test_back_to_back;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
